// File: rtl/fetch_stage.sv
// OTTER instruction-fetch stage: owns the PC, issues one IMEM request at a time,
// and loads the IF/DE register with a one-entry skid buffer for decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        FE_CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IR,
  output logic [31:0] PC_COUNT,
  output logic [31:0] PC_PLUS4,
  output logic        IR_VALID
);

  // state   | meaning
  // S_FETCH | request outstanding at r_fetch_pc
  // S_HOLD  | decode stalled, returned word parked in skid buffer, no request
  // S_DROP  | old request still outstanding, its data is discarded on ACK
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_fetch_pc, w_fetch_pc;
  logic [31:0] r_pend_pc, w_pend_pc;
  logic [31:0] r_buf_ir, w_buf_ir;
  logic [31:0] r_buf_pc, w_buf_pc;
  logic [31:0] r_ir, w_ir;
  logic [31:0] r_pc, w_pc;
  logic [31:0] r_pc4, w_pc4;
  logic        r_valid, w_valid;

  // Request is a pure function of state; reset masks it so nothing is issued during RST.
  assign IMEM_REQ  = !RST && (r_state == S_FETCH || r_state == S_DROP);
  assign IMEM_ADDR = r_fetch_pc;
  assign IR        = r_ir;
  assign PC_COUNT  = r_pc;
  assign PC_PLUS4  = r_pc4;
  assign IR_VALID  = r_valid;

  always_comb begin
    w_state    = r_state;
    w_fetch_pc = r_fetch_pc;
    w_pend_pc  = r_pend_pc;
    w_buf_ir   = r_buf_ir;
    w_buf_pc   = r_buf_pc;
    w_ir       = r_ir;
    w_pc       = r_pc;
    w_pc4      = r_pc4;
    w_valid    = r_valid;

    if (REDIRECT) begin
      w_ir    = NOP_INSTR;
      w_valid = 1'b0;
      case (r_state)
        S_FETCH, S_DROP: begin
          if (IMEM_ACK) begin
            w_fetch_pc = REDIRECT_PC;
            w_state    = S_FETCH;
          end else begin
            w_pend_pc = REDIRECT_PC;
            w_state   = S_DROP;
          end
        end
        default: begin
          w_fetch_pc = REDIRECT_PC;
          w_state    = S_FETCH;
        end
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (IMEM_ACK) begin
            w_fetch_pc = r_fetch_pc + 32'd4;
            if (STALL) begin
              w_buf_ir = IMEM_RDATA;
              w_buf_pc = r_fetch_pc;
              w_state  = S_HOLD;
            end else begin
              w_ir    = IMEM_RDATA;
              w_pc    = r_fetch_pc;
              w_pc4   = r_fetch_pc + 32'd4;
              w_valid = 1'b1;
            end
          end else if (!STALL) begin
            w_ir    = NOP_INSTR;
            w_valid = 1'b0;
          end
        end
        S_HOLD: begin
          if (!STALL) begin
            w_ir    = r_buf_ir;
            w_pc    = r_buf_pc;
            w_pc4   = r_buf_pc + 32'd4;
            w_valid = 1'b1;
            w_state = S_FETCH;
          end
        end
        S_DROP: begin
          if (IMEM_ACK) begin
            w_fetch_pc = r_pend_pc;
            w_state    = S_FETCH;
          end
        end
        default: w_state = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge FE_CLK) begin
    if (RST) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_VEC;
      r_pend_pc  <= 32'd0;
      r_buf_ir   <= 32'd0;
      r_buf_pc   <= 32'd0;
      r_ir       <= NOP_INSTR;
      r_pc       <= 32'd0;
      r_pc4      <= 32'd0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_fetch_pc <= w_fetch_pc;
      r_pend_pc  <= w_pend_pc;
      r_buf_ir   <= w_buf_ir;
      r_buf_pc   <= w_buf_pc;
      r_ir       <= w_ir;
      r_pc       <= w_pc;
      r_pc4      <= w_pc4;
      r_valid    <= w_valid;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level model of the fetch stream.
module tb_fetch_stage;

  localparam logic [31:0] RV  = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        FE_CLK = 1'b0;
  logic        RST = 1'b1, STALL = 1'b0, REDIRECT = 1'b0, IMEM_ACK = 1'b0;
  logic [31:0] REDIRECT_PC = 32'd0, IMEM_RDATA = 32'd0;
  logic        IMEM_REQ, IR_VALID;
  logic [31:0] IMEM_ADDR, IR, PC_COUNT, PC_PLUS4;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_VEC(RV), .NOP_INSTR(NOP)) dut (
    .FE_CLK(FE_CLK), .RST(RST), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .IR(IR), .PC_COUNT(PC_COUNT),
    .PC_PLUS4(PC_PLUS4), .IR_VALID(IR_VALID)
  );

  always #5 FE_CLK = ~FE_CLK;

  // Memory content is a fixed hash of the address, so the model never stores data words.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  // Model: one outstanding request (address, whether it is doomed), an optional parked word
  // identified by its PC, and the word currently presented to decode.
  logic        m_parked = 1'b0, m_doomed = 1'b0;
  logic [31:0] m_addr = RV, m_target = 32'd0, m_park_pc = 32'd0;
  logic [31:0] m_ir = NOP, m_pc = 32'd0, m_pc4 = 32'd0;
  logic        m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic present(input logic [31:0] pc);
    m_ir = mem(pc); m_pc = pc; m_pc4 = pc + 32'd4; m_valid = 1'b1;
  endtask

  task automatic bubble();
    m_ir = NOP; m_valid = 1'b0;
  endtask

  task automatic cycle(input logic rst, input logic stall, input logic redir,
                       input logic [31:0] rpc, input logic want_ack);
    logic exp_req, ack;
    exp_req = !rst && !m_parked;
    ack = want_ack && exp_req;
    RST = rst; STALL = stall; REDIRECT = redir; REDIRECT_PC = rpc; IMEM_ACK = ack;
    IMEM_RDATA = ack ? mem(m_addr) : $urandom;
    #1;
    chk("imem_req", {31'd0, IMEM_REQ}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", IMEM_ADDR, m_addr);
    @(posedge FE_CLK);
    if (rst) begin
      m_parked = 1'b0; m_doomed = 1'b0; m_addr = RV; m_target = 32'd0;
      m_ir = NOP; m_pc = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (redir) begin
      bubble();
      if (m_parked) begin
        m_parked = 1'b0; m_addr = rpc;
      end else if (ack) begin
        m_doomed = 1'b0; m_addr = rpc;
      end else begin
        m_doomed = 1'b1; m_target = rpc;
      end
    end else if (m_parked) begin
      if (!stall) begin
        present(m_park_pc); m_parked = 1'b0;
      end
    end else if (m_doomed) begin
      if (ack) begin
        m_doomed = 1'b0; m_addr = m_target;
      end
    end else if (ack) begin
      if (stall) begin
        m_parked = 1'b1; m_park_pc = m_addr;
      end else present(m_addr);
      m_addr = m_addr + 32'd4;
    end else if (!stall) bubble();
    #1;
    chk("ir", IR, m_ir);
    chk("pc_count", PC_COUNT, m_pc);
    chk("pc_plus4", PC_PLUS4, m_pc4);
    chk("ir_valid", {31'd0, IR_VALID}, {31'd0, m_valid});
  endtask

  initial begin
    // reset, then zero-wait stream crossing the 2^32 wrap
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 0, 1);
    // wait states: ack every third cycle
    repeat (3) begin
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
    end
    // stall skid: ack under stall, hold, release, continue
    cycle(0, 1, 0, 0, 1);
    repeat (3) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    // redirect while a request is pending
    cycle(0, 0, 1, 32'h200, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // redirect in HOLD under stall
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 32'h40, 0);
    cycle(0, 0, 0, 0, 1);
    // two redirects while draining: latest target wins
    cycle(0, 0, 1, 32'h100, 0);
    cycle(0, 0, 1, 32'h180, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // redirect coincident with ack
    cycle(0, 1, 1, 32'h300, 1);
    cycle(0, 0, 0, 0, 1);
    // reset during a pending request
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 2, $urandom_range(99) < 30, $urandom_range(99) < 10,
            $urandom, $urandom_range(99) < 60);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
